// File: rtl/piso_pkg.sv
// Shared constants for the piso transmitter: AXI4-Lite widths, response codes,
// register map, STATUS bit positions and shifter state encoding.
package piso_pkg;

  localparam int AXI4_ADDR_BITS = 32;
  localparam int AXI4_DATA_BITS = 32;
  localparam int AXI4_STRB_BITS = AXI4_DATA_BITS / 8;
  localparam int AXI4_PROT_BITS = 3;
  localparam int AXI4_RESP_BITS = 2;

  localparam logic [AXI4_RESP_BITS-1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [AXI4_RESP_BITS-1:0] AXI4_RESP_SLVERR = 2'b10;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h10;
  localparam logic [7:0] REG_DIV    = 8'h18;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_SOUT_VLD  = 2;
  localparam int ST_EN        = 3;
  localparam int ST_USER_RSTN = 4;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } shift_state_e;

  function automatic logic [AXI4_RESP_BITS-1:0] resp_of(input logic ok);
    return ok ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
  endfunction

endpackage

// File: rtl/piso_if.sv
// AXI4-Lite bus bundle for the piso register slave.
interface piso_if;
  import piso_pkg::*;

  logic                      aw_ready;
  logic                      aw_valid;
  logic [AXI4_ADDR_BITS-1:0] aw_addr;
  logic [AXI4_PROT_BITS-1:0] aw_prot;

  logic                      w_ready;
  logic                      w_valid;
  logic [AXI4_DATA_BITS-1:0] w_data;
  logic [AXI4_STRB_BITS-1:0] w_strb;

  logic                      b_ready;
  logic                      b_valid;
  logic [AXI4_RESP_BITS-1:0] b_resp;

  logic                      ar_ready;
  logic                      ar_valid;
  logic [AXI4_ADDR_BITS-1:0] ar_addr;
  logic [AXI4_PROT_BITS-1:0] ar_prot;

  logic                      r_ready;
  logic                      r_valid;
  logic [AXI4_DATA_BITS-1:0] r_data;
  logic [AXI4_RESP_BITS-1:0] r_resp;

  modport slave (
    output aw_ready, input  aw_valid, aw_addr, aw_prot,
    output w_ready,  input  w_valid,  w_data,  w_strb,
    input  b_ready,  output b_valid,  b_resp,
    output ar_ready, input  ar_valid, ar_addr, ar_prot,
    input  r_ready,  output r_valid,  r_data,  r_resp
  );

  modport master (
    input  aw_ready, output aw_valid, aw_addr, aw_prot,
    input  w_ready,  output w_valid,  w_data,  w_strb,
    output b_ready,  input  b_valid,  b_resp,
    input  ar_ready, output ar_valid, ar_addr, ar_prot,
    output r_ready,  input  r_valid,  r_data,  r_resp
  );

endinterface

// File: rtl/piso_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so every
// entry is usable and full/empty are told apart without a counter.
module piso_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     srst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s  = push_i && !full_o;
  assign pop_ok_s   = pop_i && !empty_o;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out transmitter: AXI4-Lite register slave feeding a FIFO
// that a rate-divided shifter drains MSB-first onto sout.
module piso
  import piso_pkg::*;
#(
  parameter int PISO_WIDTH = 32,
  parameter int PISO_DEPTH = 16,
  parameter int DIV_BITS   = 16
) (
  input  logic  s_axi4lite_clk,
  input  logic  s_axi4lite_rstn,
  output logic  sout,
  output logic  sout_valid,
  piso_if.slave s_axi4lite
);

  localparam int LVL_W  = $clog2(PISO_DEPTH) + 1;
  localparam int BCNT_W = $clog2(PISO_WIDTH);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PISO_WIDTH - 1);

  logic                      aw_cap_q, w_cap_q, b_valid_q;
  logic [7:0]                aw_addr_q;
  logic [AXI4_DATA_BITS-1:0] w_data_q;
  logic [AXI4_RESP_BITS-1:0] b_resp_q;
  logic                      rd_req_q, r_valid_q;
  logic [7:0]                ar_addr_q;
  logic [AXI4_DATA_BITS-1:0] r_data_q;
  logic [AXI4_RESP_BITS-1:0] r_resp_q;
  logic                      en_q, user_rstn_q;
  logic [DIV_BITS-1:0]       div_q;

  logic                      aw_ready_s, w_ready_s, ar_ready_s;
  logic                      wr_fire_s;
  logic                      push_s, ctrl_we_s, div_we_s;
  logic [AXI4_RESP_BITS-1:0] wr_resp_s, rd_resp_s;
  logic [AXI4_DATA_BITS-1:0] rd_data_s;

  logic                      fifo_full_s, fifo_empty_s, pop_s;
  logic [PISO_WIDTH-1:0]     fifo_data_s;
  logic [LVL_W-1:0]          fifo_level_s;

  shift_state_e              state_q, state_d;
  logic [PISO_WIDTH-1:0]     shreg_q, shreg_d, shifted_s;
  logic [BCNT_W-1:0]         bitcnt_q, bitcnt_d;
  logic [DIV_BITS-1:0]       divcnt_q, divcnt_d;
  logic                      sout_q, sout_d, sout_valid_q, sout_valid_d;
  logic                      tick_s;

  logic                      unused_s;

  assign aw_ready_s = !aw_cap_q && !b_valid_q;
  assign w_ready_s  = !w_cap_q && !b_valid_q;
  assign ar_ready_s = !rd_req_q && !r_valid_q;
  assign wr_fire_s  = aw_cap_q && w_cap_q && !b_valid_q;

  assign s_axi4lite.aw_ready = aw_ready_s;
  assign s_axi4lite.w_ready  = w_ready_s;
  assign s_axi4lite.b_valid  = b_valid_q;
  assign s_axi4lite.b_resp   = b_resp_q;
  assign s_axi4lite.ar_ready = ar_ready_s;
  assign s_axi4lite.r_valid  = r_valid_q;
  assign s_axi4lite.r_data   = r_data_q;
  assign s_axi4lite.r_resp   = r_resp_q;

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;

  assign unused_s = ^{s_axi4lite.aw_prot, s_axi4lite.ar_prot, s_axi4lite.w_strb,
                      s_axi4lite.aw_addr[AXI4_ADDR_BITS-1:8],
                      s_axi4lite.ar_addr[AXI4_ADDR_BITS-1:8], w_data_q};

  // Write decode: TXDATA is refused when the FIFO is already full before the edge.
  always_comb begin
    push_s    = 1'b0;
    ctrl_we_s = 1'b0;
    div_we_s  = 1'b0;
    wr_resp_s = AXI4_RESP_SLVERR;
    if (wr_fire_s) begin
      case (aw_addr_q)
        REG_TXDATA: begin
          push_s    = !fifo_full_s;
          wr_resp_s = resp_of(!fifo_full_s);
        end
        REG_CTRL: begin
          ctrl_we_s = 1'b1;
          wr_resp_s = AXI4_RESP_OKAY;
        end
        REG_DIV: begin
          div_we_s  = 1'b1;
          wr_resp_s = AXI4_RESP_OKAY;
        end
        default: wr_resp_s = AXI4_RESP_SLVERR;
      endcase
    end else begin
      wr_resp_s = AXI4_RESP_SLVERR;
    end
  end

  always_comb begin
    rd_data_s = '0;
    rd_resp_s = AXI4_RESP_SLVERR;
    case (ar_addr_q)
      REG_STATUS: begin
        rd_data_s[ST_EMPTY]                  = fifo_empty_s;
        rd_data_s[ST_FULL]                   = fifo_full_s;
        rd_data_s[ST_SOUT_VLD]               = sout_valid_q;
        rd_data_s[ST_EN]                     = en_q;
        rd_data_s[ST_USER_RSTN]              = user_rstn_q;
        rd_data_s[ST_LEVEL_LSB +: LVL_W]     = fifo_level_s;
        rd_resp_s                            = AXI4_RESP_OKAY;
      end
      REG_CTRL: begin
        rd_data_s[1:0] = {user_rstn_q, en_q};
        rd_resp_s      = AXI4_RESP_OKAY;
      end
      REG_DIV: begin
        rd_data_s[DIV_BITS-1:0] = div_q;
        rd_resp_s               = AXI4_RESP_OKAY;
      end
      default: rd_resp_s = AXI4_RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      aw_cap_q  <= 1'b0;
      aw_addr_q <= '0;
      w_cap_q   <= 1'b0;
      w_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= AXI4_RESP_OKAY;
    end else begin
      if (s_axi4lite.aw_valid && aw_ready_s) begin
        aw_cap_q  <= 1'b1;
        aw_addr_q <= s_axi4lite.aw_addr[7:0];
      end
      if (s_axi4lite.w_valid && w_ready_s) begin
        w_cap_q  <= 1'b1;
        w_data_q <= s_axi4lite.w_data;
      end
      if (wr_fire_s) begin
        aw_cap_q  <= 1'b0;
        w_cap_q   <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp_s;
      end else if (b_valid_q && s_axi4lite.b_ready) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      rd_req_q  <= 1'b0;
      ar_addr_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= AXI4_RESP_OKAY;
    end else begin
      if (s_axi4lite.ar_valid && ar_ready_s) begin
        rd_req_q  <= 1'b1;
        ar_addr_q <= s_axi4lite.ar_addr[7:0];
      end
      if (rd_req_q) begin
        rd_req_q  <= 1'b0;
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data_s;
        r_resp_q  <= rd_resp_s;
      end else if (r_valid_q && s_axi4lite.r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  // CTRL and DIV survive the soft reset; only the async reset restores them.
  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      en_q        <= 1'b1;
      user_rstn_q <= 1'b1;
      div_q       <= '0;
    end else begin
      if (ctrl_we_s) begin
        en_q        <= w_data_q[0];
        user_rstn_q <= w_data_q[1];
      end
      if (div_we_s) div_q <= w_data_q[DIV_BITS-1:0];
    end
  end

  piso_fifo #(
    .WIDTH (PISO_WIDTH),
    .DEPTH (PISO_DEPTH)
  ) u_fifo (
    .clk_i       (s_axi4lite_clk),
    .rst_ni      (s_axi4lite_rstn),
    .srst_i      (!user_rstn_q),
    .push_i      (push_s),
    .push_data_i (w_data_q[PISO_WIDTH-1:0]),
    .pop_i       (pop_s),
    .pop_data_o  (fifo_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .level_o     (fifo_level_s)
  );

  assign tick_s    = (divcnt_q >= div_q);
  assign shifted_s = {shreg_q[PISO_WIDTH-2:0], 1'b0};

  // Shifter next state; a word reloads on its last tick so back-to-back words have no gap.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    divcnt_d     = divcnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    pop_s        = 1'b0;
    if (!user_rstn_q) begin
      state_d      = S_IDLE;
      shreg_d      = '0;
      bitcnt_d     = '0;
      divcnt_d     = '0;
      sout_d       = 1'b0;
      sout_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_q && !fifo_empty_s) begin
            pop_s        = 1'b1;
            shreg_d      = fifo_data_s;
            bitcnt_d     = '0;
            divcnt_d     = '0;
            state_d      = S_SHIFT;
            sout_d       = fifo_data_s[PISO_WIDTH-1];
            sout_valid_d = 1'b1;
          end else begin
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
          end
        end
        S_SHIFT: begin
          if (tick_s && (bitcnt_q == LAST_BIT)) begin
            if (en_q && !fifo_empty_s) begin
              pop_s        = 1'b1;
              shreg_d      = fifo_data_s;
              bitcnt_d     = '0;
              divcnt_d     = '0;
              sout_d       = fifo_data_s[PISO_WIDTH-1];
              sout_valid_d = 1'b1;
            end else begin
              state_d      = S_IDLE;
              shreg_d      = '0;
              bitcnt_d     = '0;
              divcnt_d     = '0;
              sout_d       = 1'b0;
              sout_valid_d = 1'b0;
            end
          end else if (tick_s) begin
            shreg_d  = shifted_s;
            bitcnt_d = bitcnt_q + BCNT_W'(1);
            divcnt_d = '0;
            sout_d   = shifted_s[PISO_WIDTH-1];
          end else begin
            divcnt_d = divcnt_q + DIV_BITS'(1);
          end
        end
        default: begin
          state_d      = S_IDLE;
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      divcnt_q     <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      divcnt_q     <= divcnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
    end
  end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: register-access vector table plus hand-written
// serial stream, FIFO-full, soft-reset, split AW/W and async-reset sequences.
module tb_piso;
  import piso_pkg::*;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sout, sout_valid;
  int   checks = 0;
  int   errors = 0;
  int   bcount = 0;
  logic sv_at_b = 1'b0;

  piso_if bus ();

  piso dut (
    .s_axi4lite_clk  (clk),
    .s_axi4lite_rstn (rstn),
    .sout            (sout),
    .sout_valid      (sout_valid),
    .s_axi4lite      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.b_valid && bus.b_ready) bcount <= bcount + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int  n = 0;
    bit  got = 1'b0;
    bus.b_ready = 1'b1;
    resp = 2'b11;
    while (!got && n < 20) begin
      if (bus.b_valid) begin
        got = 1'b1;
        resp = bus.b_resp;
        sv_at_b = sout_valid;
      end
      @(negedge clk);
      n++;
    end
    bus.b_ready = 1'b0;
    chk("b_response_seen", 32'(got), 32'd1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    int n = 0;
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = addr;
    bus.w_valid  = 1'b1; bus.w_data  = data; bus.w_strb = 4'hF;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.aw_valid && bus.aw_ready;
      w_hs  = bus.w_valid && bus.w_ready;
      @(negedge clk);
      n++;
      if (aw_hs) begin bus.aw_valid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.w_valid  = 1'b0; w_done  = 1'b1; end
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    bit got = 1'b0, hs;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_addr = addr;
    while (bus.ar_valid && n < 20) begin
      hs = bus.ar_ready;
      @(negedge clk);
      n++;
      if (hs) bus.ar_valid = 1'b0;
    end
    bus.ar_valid = 1'b0;
    bus.r_ready  = 1'b1;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    n = 0;
    while (!got && n < 20) begin
      if (bus.r_valid) begin
        got = 1'b1; data = bus.r_data; resp = bus.r_resp;
      end
      @(negedge clk);
      n++;
    end
    bus.r_ready = 1'b0;
    chk("r_response_seen", 32'(got), 32'd1);
  endtask

  initial begin
    vec_t        vecs[13];
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] word;
    logic [31:0] words[17];
    int          cnt, bad, n, b0;
    bit          early_b;

    vecs[0]  = '{1'b0, 32'h08,  32'h0,         AXI4_RESP_OKAY,   32'h19};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,         AXI4_RESP_OKAY,   32'h3};
    vecs[2]  = '{1'b0, 32'h18,  32'h0,         AXI4_RESP_OKAY,   32'h0};
    vecs[3]  = '{1'b0, 32'h00,  32'h0,         AXI4_RESP_SLVERR, 32'h0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,         AXI4_RESP_SLVERR, 32'h0};
    vecs[5]  = '{1'b1, 32'h24,  32'h1,         AXI4_RESP_SLVERR, 32'h0};
    vecs[6]  = '{1'b1, 32'h18,  32'h1234,      AXI4_RESP_OKAY,   32'h0};
    vecs[7]  = '{1'b0, 32'h18,  32'h0,         AXI4_RESP_OKAY,   32'h1234};
    vecs[8]  = '{1'b1, 32'h18,  32'hFFFF_0007, AXI4_RESP_OKAY,   32'h0};
    vecs[9]  = '{1'b0, 32'h18,  32'h0,         AXI4_RESP_OKAY,   32'h7};
    vecs[10] = '{1'b0, 32'h04,  32'h0,         AXI4_RESP_SLVERR, 32'h0};
    vecs[11] = '{1'b1, 32'h18,  32'h0,         AXI4_RESP_OKAY,   32'h0};
    vecs[12] = '{1'b0, 32'h108, 32'h0,         AXI4_RESP_OKAY,   32'h19};

    bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
    bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.b_ready  = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
    bus.r_ready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sout_valid", 32'(sout_valid), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, resp);
        chk($sformatf("vec%0d_wresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rdata, resp);
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_data);
      end
    end

    // Single word at div=0: one bit per cycle, valid one cycle after b_valid.
    word = 32'hA500_0001;
    axi_write(32'h00, word, resp);
    chk("t1_resp", 32'(resp), 32'(AXI4_RESP_OKAY));
    chk("t1_valid_at_b", 32'(sv_at_b), 32'd0);
    chk("t1_valid_rise", 32'(sout_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (sout_valid !== 1'b1 || sout !== word[31-i]) bad++;
      @(negedge clk);
    end
    chk("t1_bits", 32'(bad), 32'd0);
    chk("t1_valid_end", 32'(sout_valid), 32'd0);
    chk("t1_sout_end", 32'(sout), 32'd0);

    // div=3: each bit held for four cycles.
    axi_write(32'h18, 32'd3, resp);
    axi_write(32'h00, 32'h8000_0000, resp);
    chk("t2_resp", 32'(resp), 32'(AXI4_RESP_OKAY));
    cnt = 0; bad = 0;
    while (sout_valid && cnt < 300) begin
      if (cnt < 4) begin
        if (sout !== 1'b1) bad++;
      end else begin
        if (sout !== 1'b0) bad++;
      end
      cnt++;
      @(negedge clk);
    end
    chk("t2_valid_cycles", 32'(cnt), 32'd128);
    chk("t2_bits", 32'(bad), 32'd0);

    // Fill with en=0, overflow once, then drain back-to-back.
    axi_write(32'h18, 32'd0, resp);
    axi_write(32'h10, 32'h2, resp);
    for (int i = 0; i < 17; i++) begin
      words[i] = 32'h0F0F_3C00 ^ (32'(i) * 32'h0101_0011);
      axi_write(32'h00, words[i], resp);
      chk($sformatf("t3_push%0d_resp", i), 32'(resp),
          (i < 16) ? 32'(AXI4_RESP_OKAY) : 32'(AXI4_RESP_SLVERR));
    end
    axi_read(32'h08, rdata, resp);
    chk("t3_status_full", rdata, 32'h0000_1012);
    axi_write(32'h10, 32'h3, resp);
    cnt = 0; bad = 0;
    while (sout_valid && cnt < 600) begin
      if (sout !== words[cnt/32][31 - (cnt % 32)]) bad++;
      cnt++;
      @(negedge clk);
    end
    chk("t3_valid_cycles", 32'(cnt), 32'd512);
    chk("t3_bits", 32'(bad), 32'd0);

    // Soft reset mid-word drops the current word and the queued one.
    axi_write(32'h00, 32'hFFFF_0000, resp);
    axi_write(32'h00, 32'h1234_5678, resp);
    repeat (3) @(negedge clk);
    chk("t4_mid_word", 32'(sout_valid), 32'd1);
    axi_write(32'h10, 32'h1, resp);
    chk("t4_ctrl_resp", 32'(resp), 32'(AXI4_RESP_OKAY));
    chk("t4_valid_dropped", 32'(sout_valid), 32'd0);
    axi_read(32'h08, rdata, resp);
    chk("t4_status_held", rdata, 32'h0000_0009);
    axi_write(32'h10, 32'h3, resp);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (sout_valid !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("t4_no_output", 32'(cnt), 32'd0);
    axi_read(32'h08, rdata, resp);
    chk("t4_status_idle", rdata, 32'h0000_0019);

    // AW three cycles ahead of W: exactly one response, only after W.
    b0 = bcount;
    early_b = 1'b0;
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_addr = 32'h18; bus.b_ready = 1'b1;
    n = 0;
    while (bus.aw_valid && n < 20) begin
      if (bus.aw_ready) begin @(negedge clk); bus.aw_valid = 1'b0; end
      else @(negedge clk);
      n++;
    end
    repeat (3) begin
      if (bus.b_valid) early_b = 1'b1;
      @(negedge clk);
    end
    bus.w_valid = 1'b1; bus.w_data = 32'd5;
    n = 0;
    while (bus.w_valid && n < 20) begin
      if (bus.w_ready) begin @(negedge clk); bus.w_valid = 1'b0; end
      else @(negedge clk);
      n++;
    end
    wait_b(resp);
    repeat (3) @(negedge clk);
    chk("t5_no_early_b", 32'(early_b), 32'd0);
    chk("t5_resp", 32'(resp), 32'(AXI4_RESP_OKAY));
    chk("t5_one_b", 32'(bcount - b0), 32'd1);
    axi_read(32'h18, rdata, resp);
    chk("t5_div_readback", rdata, 32'd5);

    // Async reset mid-word clears sout_valid without waiting for a clock.
    axi_write(32'h18, 32'd7, resp);
    axi_write(32'h00, 32'hF0F0_F0F0, resp);
    repeat (5) @(negedge clk);
    chk("t6_mid_word", 32'(sout_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_valid", 32'(sout_valid), 32'd0);
    chk("t6_async_sout", 32'(sout), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    axi_read(32'h08, rdata, resp);
    chk("t6_status", rdata, 32'h0000_0019);
    axi_read(32'h18, rdata, resp);
    chk("t6_div_reset", rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
